// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: accepts one MemRead/MemWrite request at a time,
// answers after WAIT_CYCLES wait states with a one-cycle Ready (and Error on rejects).
module data_mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [15:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Error,
    output logic [1:0]            fsm_state
);

    // Handshake: a request (MemRead|MemWrite) seen high on an edge while IDLE is accepted;
    // the requester holds it until Ready and drops it in the cycle after. Ready is a
    // single-cycle pulse in RESP; Error only ever pulses together with Ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state, next_state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    lat_write;
    logic                    lat_err;
    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    req;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    resp_err;
    logic                    resp_write;
    logic [ADDR_WIDTH-1:0]   resp_idx;

    assign req       = MemRead | MemWrite;
    assign req_idx   = Address[ADDR_WIDTH:1];
    assign req_err   = (MemRead & MemWrite) | Address[0] | (|Address[15:ADDR_WIDTH+1]);
    assign fsm_state = state;

    // With zero wait states RESP is entered straight from IDLE, before the latches load.
    always_comb begin
        resp_err   = lat_err;
        resp_write = lat_write;
        resp_idx   = lat_idx;
        if (state == S_IDLE) begin
            resp_err   = req_err;
            resp_write = MemWrite;
            resp_idx   = req_idx;
        end
    end

    always_comb begin
        next_state = state;
        Ready      = 1'b0;
        Error      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt <= 4'd1) next_state = S_RESP;
            end
            S_RESP: begin
                Ready      = 1'b1;
                Error      = lat_err;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            ReadData  <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && req) begin
                cnt       <= 4'(WAIT_CYCLES);
                lat_idx   <= req_idx;
                lat_wdata <= WriteData;
                lat_write <= MemWrite;
                lat_err   <= req_err;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // ReadData is loaded once, on entry to RESP, and held afterwards.
            if (next_state == S_RESP && state != S_RESP) begin
                ReadData <= (resp_err || resp_write) ? '0 : mem[resp_idx];
            end
        end
    end

    // Storage is deliberately not reset; an async reset in RESP leaves state IDLE, so no write.
    always_ff @(posedge Clock) begin
        if (state == S_RESP && lat_write && !lat_err) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven bench for data_mem_responder: one instance with two wait states,
// one with zero wait states, plus hand sequences for reset-in-WAIT and back-to-back.
module tb_data_mem_responder;

    logic        Clock;
    logic        ResetN;

    logic        rd2, wr2;
    logic [15:0] addr2, wd2;
    logic [15:0] rdata2;
    logic        ready2, err2;
    logic [1:0]  st2;

    logic        rd0, wr0;
    logic [15:0] addr0, wd0;
    logic [15:0] rdata0;
    logic        ready0, err0;
    logic [1:0]  st0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] exp_q[$];

    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
        .Clock(Clock), .ResetN(ResetN), .MemRead(rd2), .MemWrite(wr2),
        .Address(addr2), .WriteData(wd2), .ReadData(rdata2), .Ready(ready2),
        .Error(err2), .fsm_state(st2)
    );

    data_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
        .Clock(Clock), .ResetN(ResetN), .MemRead(rd0), .MemWrite(wr0),
        .Address(addr0), .WriteData(wd0), .ReadData(rdata0), .Ready(ready0),
        .Error(err0), .fsm_state(st0)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] wd);
        if (sel) begin
            rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd;
        end else begin
            rd2 = rd; wr2 = wr; addr2 = addr; wd2 = wd;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready0 : ready2;
    endfunction

    task automatic run_access(input bit sel, input logic rd, input logic wr,
                              input logic [15:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_d, input logic exp_e,
                              input int exp_lat, input string name);
        int  n;
        bit  seen;
        @(negedge Clock);
        drive(sel, rd, wr, addr, wd);
        n    = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
            seen = rdy(sel);
        end
        if (!seen) begin
            check({name, " ready_timeout"}, 32'(n), 32'(exp_lat));
        end else begin
            check({name, " latency"}, 32'(n), 32'(exp_lat));
            check({name, " rdata"}, 32'(sel ? rdata0 : rdata2), 32'(exp_d));
            check({name, " error"}, 32'(sel ? err0 : err2), 32'(exp_e));
        end
        @(negedge Clock);
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge Clock);
        #1;
        check({name, " ready_single_pulse"}, 32'(rdy(sel)), 32'd0);
    endtask

    task automatic add_vec(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input logic [15:0] ed, input logic ee,
                           input string name);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        logic [16:0] e;

        ResetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // vector table
        add_vec(1, 0, 16'h0010, 16'h0000, 16'h0000, 0, "wr_placeholder");
        vecs.delete();
        add_vec(0, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, "wr_0010");
        add_vec(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, "rd_0010");
        add_vec(1, 0, 16'h0011, 16'h0000, 16'h0000, 1, "rd_misaligned");
        add_vec(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, "rd_0010_again");
        add_vec(0, 1, 16'h0020, 16'hAAAA, 16'h0000, 0, "wr_0020");
        add_vec(1, 1, 16'h0020, 16'h1234, 16'h0000, 1, "rdwr_both");
        add_vec(1, 0, 16'h0020, 16'h0000, 16'hAAAA, 0, "rd_0020_kept");
        add_vec(0, 1, 16'h0000, 16'h0F0F, 16'h0000, 0, "wr_0000");
        add_vec(0, 1, 16'h0200, 16'h7777, 16'h0000, 1, "wr_out_of_range");
        add_vec(1, 0, 16'h0000, 16'h0000, 16'h0F0F, 0, "rd_0000_kept");
        add_vec(0, 1, 16'h01FE, 16'hCAFE, 16'h0000, 0, "wr_01fe");
        add_vec(1, 0, 16'h01FE, 16'h0000, 16'hCAFE, 0, "rd_01fe");
        add_vec(0, 1, 16'h0012, 16'h2222, 16'h0000, 0, "wr_0012");
        add_vec(0, 1, 16'h0013, 16'h9999, 16'h0000, 1, "wr_misaligned");
        add_vec(1, 0, 16'h0012, 16'h0000, 16'h2222, 0, "rd_0012_kept");
        add_vec(0, 1, 16'h0004, 16'h1111, 16'h0000, 0, "wr_0004");
        add_vec(1, 0, 16'h0004, 16'h0000, 16'h1111, 0, "rd_0004");
        foreach (vecs[i]) exp_q.push_back({vecs[i].exp_err, vecs[i].exp_data});

        // reset state
        repeat (3) @(posedge Clock);
        #1;
        check("reset_ready", 32'(ready2), 32'd0);
        check("reset_error", 32'(err2), 32'd0);
        check("reset_rdata", 32'(rdata2), 32'd0);
        check("reset_state", 32'(st2), 32'd0);
        @(negedge Clock);
        ResetN = 1'b1;

        // scoreboard-driven vector loop
        foreach (vecs[i]) begin
            e = exp_q.pop_front();
            run_access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       e[15:0], e[16], 3, vecs[i].name);
        end

        // reset during WAIT of a write: no Ready, write discarded
        @(negedge Clock);
        drive(1'b0, 1'b0, 1'b1, 16'h0004, 16'h5555);
        @(posedge Clock);
        #1;
        check("rst_mid_in_wait", 32'(st2), 32'd1);
        @(negedge Clock);
        ResetN = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready2), 32'd0);
        check("rst_mid_error", 32'(err2), 32'd0);
        check("rst_mid_rdata", 32'(rdata2), 32'd0);
        check("rst_mid_state", 32'(st2), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock);
            #1;
            if (ready2) pulses++;
        end
        @(negedge Clock);
        ResetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock);
            #1;
            if (ready2) pulses++;
        end
        check("rst_mid_no_ready", 32'(pulses), 32'd0);
        run_access(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1111, 1'b0, 3, "rd_0004_after_rst");

        // zero wait states: single write, then held read gives Ready every 2nd cycle
        run_access(1'b1, 1'b0, 1'b1, 16'h0008, 16'h4242, 16'h0000, 1'b0, 1, "w0_wr_0008");
        @(negedge Clock);
        drive(1'b1, 1'b1, 1'b0, 16'h0008, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            @(posedge Clock);
            #1;
            check($sformatf("w0_b2b_ready_%0d", k), 32'(ready0), 32'((k % 2) == 0));
            check($sformatf("w0_b2b_rdata_%0d", k), 32'(rdata0), 32'h4242);
            check($sformatf("w0_b2b_error_%0d", k), 32'(err0), 32'd0);
        end
        @(negedge Clock);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge Clock);
        #1;
        check("w0_idle_after", 32'(ready0), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
